// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs one imem transaction at a time and
// presents each returned word with its PC to decode and the branch predictor.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_i,
   input  logic        miss_pred_i,
   input  logic [31:0] correct_pc_i,
   input  logic        br_pred_i,
   input  logic [31:0] new_pc_pred_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic        valid_o,
   output logic [31:0] instruction_o,
   output logic [31:0] pc_o,
   output logic        pred_taken_o
);

   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, FLUSH} state_t;

   state_t      state, state_n;
   logic [31:0] fetch_pc, fetch_pc_n;
   logic [31:0] redirect_pc, redirect_pc_n;
   logic        valid_n;
   logic [31:0] instr_n;
   logic [31:0] pc_n;
   logic [31:0] correct_al;
   logic [31:0] target_al;

   // Stored targets are always word aligned so imem_addr_o[1:0] stays zero.
   assign correct_al = correct_pc_i  & 32'hFFFF_FFFC;
   assign target_al  = new_pc_pred_i & 32'hFFFF_FFFC;

   // FLUSH keeps the request up so the abandoned transaction can complete.
   assign imem_req_o   = (state == FETCH) || (state == FLUSH);
   assign imem_addr_o  = fetch_pc;
   assign pred_taken_o = valid_o & br_pred_i;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         fetch_pc      <= RESET_PC & 32'hFFFF_FFFC;
         redirect_pc   <= 32'h0;
         valid_o       <= 1'b0;
         instruction_o <= NOP_INSTR;
         pc_o          <= 32'h0;
      end else begin
         state         <= state_n;
         fetch_pc      <= fetch_pc_n;
         redirect_pc   <= redirect_pc_n;
         valid_o       <= valid_n;
         instruction_o <= instr_n;
         pc_o          <= pc_n;
      end
   end

   // A mispredict outranks every other event, including a stall in ISSUE.
   always_comb begin
      state_n       = state;
      fetch_pc_n    = fetch_pc;
      redirect_pc_n = redirect_pc;
      valid_n       = valid_o;
      instr_n       = instruction_o;
      pc_n          = pc_o;

      case (state)
         IDLE: begin
            state_n = FETCH;
            if (miss_pred_i) begin
               fetch_pc_n = correct_al;
            end
         end

         FETCH: begin
            if (miss_pred_i) begin
               if (imem_ack_i) begin
                  fetch_pc_n = correct_al;
               end else begin
                  redirect_pc_n = correct_al;
                  state_n       = FLUSH;
               end
            end else if (imem_ack_i) begin
               instr_n = imem_rdata_i;
               pc_n    = fetch_pc;
               valid_n = 1'b1;
               state_n = ISSUE;
            end
         end

         ISSUE: begin
            if (miss_pred_i) begin
               valid_n    = 1'b0;
               instr_n    = NOP_INSTR;
               fetch_pc_n = correct_al;
               state_n    = FETCH;
            end else if (!stall_i) begin
               valid_n    = 1'b0;
               instr_n    = NOP_INSTR;
               fetch_pc_n = br_pred_i ? target_al : (pc_o + 32'd4);
               state_n    = FETCH;
            end
         end

         FLUSH: begin
            if (imem_ack_i) begin
               fetch_pc_n = miss_pred_i ? correct_al : redirect_pc;
               state_n    = FETCH;
            end else if (miss_pred_i) begin
               redirect_pc_n = correct_al;
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a latency-programmable memory model feeds a
// scoreboard, plus a next-address vector table and hand-written redirect sequences.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic        stall_i;
   logic        miss_pred_i;
   logic [31:0] correct_pc_i;
   logic        br_pred_i;
   logic [31:0] new_pc_pred_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_rdata_i;
   logic        valid_o;
   logic [31:0] instruction_o;
   logic [31:0] pc_o;
   logic        pred_taken_o;

   fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
      .clk           (clk),
      .reset         (reset),
      .stall_i       (stall_i),
      .miss_pred_i   (miss_pred_i),
      .correct_pc_i  (correct_pc_i),
      .br_pred_i     (br_pred_i),
      .new_pc_pred_i (new_pc_pred_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ack_i    (imem_ack_i),
      .imem_rdata_i  (imem_rdata_i),
      .valid_o       (valid_o),
      .instruction_o (instruction_o),
      .pc_o          (pc_o),
      .pred_taken_o  (pred_taken_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   typedef struct {
      logic [31:0] pc_in;
      logic        br;
      logic [31:0] tgt;
      logic [31:0] exp_pc;
      logic [31:0] exp_next;
   } vec_t;

   exp_t        sb[$];
   vec_t        vecs[5];
   int          checks;
   int          failures;
   int          mem_lat;
   int          wait_cnt;
   bit          flushing;
   logic        prev_req;
   logic        prev_ack;
   logic        prev_valid;
   logic [31:0] prev_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return (addr == 32'h0) ? NOP : (addr ^ 32'hCAFE_0003);
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   task automatic report_fail(input string name);
      checks++;
      failures++;
      $display("[TB] FAIL %s", name);
   endtask

   // Memory model: acks mem_lat cycles after a request first appears; a response
   // that coincides with a mispredict, or belongs to an abandoned request, is not expected.
   task automatic drive_mem();
      exp_t e;
      prev_req  = imem_req_o;
      prev_addr = imem_addr_o;
      if (imem_req_o) begin
         if (wait_cnt >= mem_lat) begin
            imem_ack_i   = 1'b1;
            imem_rdata_i = mem_word(imem_addr_o);
            wait_cnt     = 0;
            if (!(miss_pred_i || flushing)) begin
               e.pc    = imem_addr_o;
               e.instr = mem_word(imem_addr_o);
               sb.push_back(e);
            end
            flushing = 1'b0;
         end else begin
            imem_ack_i   = 1'b0;
            imem_rdata_i = 32'hDEAD_BEEF;
            wait_cnt++;
            if (miss_pred_i) flushing = 1'b1;
         end
      end else begin
         imem_ack_i = 1'b0;
         wait_cnt   = 0;
      end
      prev_ack = imem_ack_i;
   endtask

   task automatic monitor();
      exp_t e;
      if (prev_req && !prev_ack && imem_req_o)
         check_output("addr_stable", imem_addr_o, prev_addr);
      if (valid_o && !prev_valid) begin
         if (sb.size() == 0) begin
            report_fail("sb_underflow");
         end else begin
            e = sb.pop_front();
            check_output("sb_instr", instruction_o, e.instr);
            check_output("sb_pc", pc_o, e.pc);
         end
      end
      prev_valid = valid_o;
   endtask

   task automatic tick();
      drive_mem();
      @(posedge clk);
      #1;
      monitor();
   endtask

   task automatic apply_stimulus(input logic stall, input logic miss, input logic [31:0] cpc);
      stall_i      = stall;
      miss_pred_i  = miss;
      correct_pc_i = cpc;
   endtask

   task automatic wait_valid(input int budget);
      int n;
      n = 0;
      while (!valid_o && n < budget) begin
         tick();
         n++;
      end
      if (!valid_o) report_fail("wait_valid_timeout");
   endtask

   // Redirect from ISSUE so the next presented instruction sits at pc_in.
   task automatic goto_issue_at(input logic [31:0] pc_in);
      wait_valid(20);
      apply_stimulus(1'b0, 1'b1, pc_in);
      tick();
      apply_stimulus(1'b0, 1'b0, 32'h0);
      tick();
   endtask

   task automatic clear_bench_state();
      imem_ack_i = 1'b0;
      flushing   = 1'b0;
      wait_cnt   = 0;
      prev_req   = 1'b0;
      prev_ack   = 1'b0;
      prev_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog_timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b1;
      apply_stimulus(1'b0, 1'b0, 32'h0);
      br_pred_i = 1'b1;
      new_pc_pred_i = 32'h40;
      imem_rdata_i = 32'h0;
      mem_lat = 1;
      clear_bench_state();

      vecs[0] = '{32'h0000_0008, 1'b1, 32'h0000_0040, 32'h0000_0008, 32'h0000_0040};
      vecs[1] = '{32'h0000_0008, 1'b0, 32'h0000_0040, 32'h0000_0008, 32'h0000_000C};
      vecs[2] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_0040, 32'hFFFF_FFFC, 32'h0000_0000};
      vecs[3] = '{32'h0000_1000, 1'b1, 32'h0000_2003, 32'h0000_1000, 32'h0000_2000};
      vecs[4] = '{32'h0000_0033, 1'b0, 32'h0000_0040, 32'h0000_0030, 32'h0000_0034};

      // Reset values, with the predictor claiming taken to prove pred_taken_o is gated.
      @(posedge clk);
      #1;
      check_output("rst_req", imem_req_o, 1'b0);
      check_output("rst_valid", valid_o, 1'b0);
      check_output("rst_instr", instruction_o, NOP);
      check_output("rst_pc", pc_o, 32'h0);
      check_output("rst_pred_taken", pred_taken_o, 1'b0);

      br_pred_i = 1'b0;
      reset = 1'b0;
      #1;
      check_output("idle_req", imem_req_o, 1'b0);
      tick();
      check_output("first_req", imem_req_o, 1'b1);
      check_output("first_addr", imem_addr_o, 32'h0);
      tick();
      check_output("wait_addr", imem_addr_o, 32'h0);
      check_output("wait_valid", valid_o, 1'b0);
      tick();
      check_output("first_valid", valid_o, 1'b1);
      check_output("first_pc", pc_o, 32'h0);
      check_output("issue_req", imem_req_o, 1'b0);
      tick();
      check_output("handoff_req", imem_req_o, 1'b1);
      check_output("handoff_addr", imem_addr_o, 32'h4);
      check_output("handoff_instr", instruction_o, NOP);

      // Stall holds the presented instruction for three cycles.
      wait_valid(20);
      apply_stimulus(1'b1, 1'b0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check_output("stall_valid", valid_o, 1'b1);
         check_output("stall_pc", pc_o, 32'h4);
         check_output("stall_instr", instruction_o, mem_word(32'h4));
         check_output("stall_req", imem_req_o, 1'b0);
      end
      apply_stimulus(1'b0, 1'b0, 32'h0);
      tick();
      check_output("unstall_req", imem_req_o, 1'b1);
      check_output("unstall_addr", imem_addr_o, 32'h8);

      // Next-address selection table with a same-cycle-ack memory.
      mem_lat = 0;
      for (int i = 0; i < 5; i++) begin
         goto_issue_at(vecs[i].pc_in);
         check_output("vec_valid", valid_o, 1'b1);
         check_output("vec_pc", pc_o, vecs[i].exp_pc);
         br_pred_i = vecs[i].br;
         new_pc_pred_i = vecs[i].tgt;
         #1;
         check_output("vec_pred_taken", pred_taken_o, vecs[i].br);
         tick();
         check_output("vec_next_req", imem_req_o, 1'b1);
         check_output("vec_next_addr", imem_addr_o, vecs[i].exp_next);
         br_pred_i = 1'b0;
      end

      // Mispredict while a slow request to 0x20 is outstanding.
      wait_valid(20);
      apply_stimulus(1'b0, 1'b1, 32'h20);
      tick();
      apply_stimulus(1'b0, 1'b0, 32'h0);
      check_output("pre_flush_addr", imem_addr_o, 32'h20);
      mem_lat = 3;
      apply_stimulus(1'b0, 1'b1, 32'h100);
      tick();
      apply_stimulus(1'b0, 1'b0, 32'h0);
      br_pred_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         check_output("flush_addr", imem_addr_o, 32'h20);
         check_output("flush_req", imem_req_o, 1'b1);
         check_output("flush_valid", valid_o, 1'b0);
         check_output("flush_pred_taken", pred_taken_o, 1'b0);
         tick();
      end
      br_pred_i = 1'b0;
      check_output("post_flush_addr", imem_addr_o, 32'h100);
      check_output("post_flush_valid", valid_o, 1'b0);

      // Two redirects during one flush: the later one wins.
      apply_stimulus(1'b0, 1'b1, 32'h100);
      tick();
      apply_stimulus(1'b0, 1'b1, 32'h180);
      tick();
      apply_stimulus(1'b0, 1'b0, 32'h0);
      tick();
      tick();
      check_output("latest_redirect_addr", imem_addr_o, 32'h180);
      wait_valid(20);
      check_output("latest_redirect_pc", pc_o, 32'h180);

      // Mispredict coinciding with the ack, then a mispredict overriding a stall.
      mem_lat = 0;
      apply_stimulus(1'b0, 1'b1, 32'h50);
      tick();
      apply_stimulus(1'b0, 1'b1, 32'h200);
      tick();
      apply_stimulus(1'b0, 1'b0, 32'h0);
      check_output("ackmiss_req", imem_req_o, 1'b1);
      check_output("ackmiss_addr", imem_addr_o, 32'h200);
      check_output("ackmiss_valid", valid_o, 1'b0);
      tick();
      check_output("ackmiss_issue_pc", pc_o, 32'h200);
      apply_stimulus(1'b1, 1'b1, 32'h200);
      tick();
      apply_stimulus(1'b0, 1'b0, 32'h0);
      check_output("drop_valid", valid_o, 1'b0);
      check_output("drop_instr", instruction_o, NOP);
      check_output("drop_addr", imem_addr_o, 32'h200);
      tick();
      check_output("drop_refetch_pc", pc_o, 32'h200);

      // Asynchronous reset in the middle of a slow request.
      mem_lat = 3;
      tick();
      check_output("midfetch_req", imem_req_o, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check_output("async_rst_req", imem_req_o, 1'b0);
      check_output("async_rst_valid", valid_o, 1'b0);
      check_output("async_rst_instr", instruction_o, NOP);
      clear_bench_state();
      @(posedge clk);
      #1;
      reset = 1'b0;
      mem_lat = 0;
      tick();
      check_output("restart_req", imem_req_o, 1'b1);
      check_output("restart_addr", imem_addr_o, 32'h0);
      wait_valid(20);
      check_output("restart_pc", pc_o, 32'h0);

      check_output("sb_drained", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that owns the program counter.
- Issues word requests to instruction memory and registers each returned instruction with its PC for decode.
- Its registered instruction/PC outputs drive the branch predictor. The predictor's taken flag and target select the next fetch address.
- Handles mispredict redirects from execute, including discarding a response that is still in flight.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset.
NOP_INSTR, 32'h0000_0013, value held on instruction_o when no valid instruction is presented.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
stall_i  input  1  decode cannot accept the presented instruction this cycle.
miss_pred_i  input  1  execute detected a mispredict; redirect fetch.
correct_pc_i  input  32  redirect target, valid when miss_pred_i=1.
br_pred_i  input  1  predictor taken flag for instruction_o/pc_o.
new_pc_pred_i  input  32  predictor target for instruction_o/pc_o.
imem_req_o  output  1  instruction memory request.
imem_addr_o  output  32  request address; bits [1:0] are always 0.
imem_ack_i  input  1  memory response valid; may arrive in the same cycle as the request or any later cycle.
imem_rdata_i  input  32  instruction word, valid when imem_ack_i=1.
valid_o  output  1  instruction_o/pc_o hold a live instruction.
instruction_o  output  32  fetched instruction; also drives the predictor.
pc_o  output  32  PC of instruction_o; also drives the predictor.
pred_taken_o  output  1  equals br_pred_i when valid_o=1, else 0; decode carries it to execute.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-request):
  - state=IDLE, fetch_pc=RESET_PC, redirect_pc=0.
  - imem_req_o=0, valid_o=0, instruction_o=NOP_INSTR, pc_o=0, pred_taken_o=0.
- State machine has 4 states: IDLE, FETCH, ISSUE, FLUSH.
- IDLE: imem_req_o=0. Goes to FETCH on the first clock edge after reset falls.
- FETCH: imem_req_o=1, imem_addr_o=fetch_pc.
  - Address is held stable until imem_ack_i.
  - On ack with no miss: instruction_o<=imem_rdata_i, pc_o<=fetch_pc, valid_o<=1, go to ISSUE.
- ISSUE: imem_req_o=0, valid_o=1.
  - If stall_i=1: all outputs and fetch_pc hold.
  - If stall_i=0 (handoff): fetch_pc <= br_pred_i ? new_pc_pred_i : pc_o+4; valid_o<=0; instruction_o<=NOP_INSTR; go to FETCH.
  - The new request appears on the cycle after handoff.
- FLUSH: imem_req_o=1, imem_addr_o still equals the old fetch_pc.
  - The outstanding request is completed and its response discarded; valid_o stays 0.
  - On ack: fetch_pc<=redirect_pc, go to FETCH.
- miss_pred_i has the highest priority after reset. It overrides stall_i.
  - ISSUE: valid_o<=0, instruction_o<=NOP_INSTR, fetch_pc<=correct_pc_i, go to FETCH. The presented instruction is dropped.
  - FETCH with ack in the same cycle: rdata discarded, fetch_pc<=correct_pc_i, stay in FETCH. The next request starts the following cycle as a new transaction.
  - FETCH without ack: redirect_pc<=correct_pc_i, go to FLUSH.
  - FLUSH without ack: redirect_pc<=correct_pc_i (latest redirect wins).
  - FLUSH with ack: fetch_pc<=correct_pc_i, go to FETCH.
  - IDLE: fetch_pc<=correct_pc_i.
- Arithmetic:
  - pc_o+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
  - Redirect and predicted targets are stored with bits [1:0] forced to 0.
- Throughput: at most one instruction in flight. One instruction every 2 cycles with a same-cycle-ack memory.
- Protocol invariant: imem_addr_o never changes while imem_req_o=1 and no ack has been seen.

Test Plan:
1. Reset release, RESET_PC=0, memory acks 1 cycle after request with 0x00000013 -> IDLE then req addr 0x0; valid_o=1 with pc_o=0; then req addr 0x4 after handoff.
2. Fetch at 0x8, br_pred_i=1, new_pc_pred_i=0x40 -> pred_taken_o=1 while valid; next imem_addr_o=0x40. Same case with br_pred_i=0 -> next imem_addr_o=0xC.
3. stall_i high 3 cycles in ISSUE -> instruction_o, pc_o, valid_o stable; imem_req_o=0; fetch resumes at pc_o+4 the cycle after stall_i falls.
4. miss_pred_i with correct_pc_i=0x100 while the request to 0x20 waits 3 cycles for ack -> addr stays 0x20 until ack; valid_o stays 0; next request is to 0x100.
5. miss_pred_i in the same cycle as ack, correct_pc_i=0x200 -> rdata discarded; next request is to 0x200. Repeat in ISSUE with stall_i=1 -> instruction dropped; fetch goes to 0x200.
6. pc_o=0xFFFFFFFC, no prediction -> next addr 0x0. Assert reset mid-FETCH -> imem_req_o drops asynchronously; fetch restarts at RESET_PC.
